// File: rtl/clk_gen_multi_pkg.sv
// Shared types and effective-value helpers for the multi-output clock generator.
package clk_gen_multi_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic {SETTLE, LOCKED} state_t;

  function automatic logic [31:0] div_eff(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  function automatic logic [31:0] high_eff(input logic [31:0] high, input logic [31:0] div_e);
    if (high < 32'd1)
      return 32'd1;
    else if (high > div_e - 32'd1)
      return div_e - 32'd1;
    else
      return high;
  endfunction

  function automatic logic [31:0] phase_eff(input logic [31:0] phase, input logic [31:0] div_e);
    return (phase < div_e) ? phase : 32'd0;
  endfunction

endpackage

// File: rtl/clk_gen_multi_if.sv
// Configuration and status bundle of clk_gen_multi.
interface clk_gen_multi_if
  import clk_gen_multi_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS = 4,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned SEL_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
);
  logic                  cfg_wr;
  logic [SEL_W-1:0]      cfg_sel;
  logic                  cfg_en;
  logic [CNT_W-1:0]      cfg_div;
  logic [CNT_W-1:0]      cfg_high;
  logic [CNT_W-1:0]      cfg_phase;
  logic [NUM_CLOCKS-1:0] outclk;
  logic                  locked;
  logic                  busy;

  modport master (
    output cfg_wr, cfg_sel, cfg_en, cfg_div, cfg_high, cfg_phase,
    input  outclk, locked, busy
  );

  modport slave (
    input  cfg_wr, cfg_sel, cfg_en, cfg_div, cfg_high, cfg_phase,
    output outclk, locked, busy
  );
endinterface

// File: rtl/clk_gen_channel.sv
// One divided-clock channel: config registers, phase-loadable counter, output flop.
module clk_gen_channel
  import clk_gen_multi_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned DIV_RESET  = 4,
  parameter int unsigned HIGH_RESET = 2
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [CNT_W-1:0] wr_phase,
  input  logic             restart,
  input  logic             run,
  output logic             outclk
);
  logic             en_q;
  logic [CNT_W-1:0] div_q, high_q, phase_q, cnt_q;
  logic [CNT_W-1:0] div_e, high_e, phase_e;

  always_comb begin
    div_e   = CNT_W'(div_eff(32'(div_q)));
    high_e  = CNT_W'(high_eff(32'(high_q), 32'(div_e)));
    phase_e = CNT_W'(phase_eff(32'(phase_q), 32'(div_e)));
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b1;
      div_q   <= CNT_W'(DIV_RESET);
      high_q  <= CNT_W'(HIGH_RESET);
      phase_q <= '0;
    end else if (wr) begin
      en_q    <= wr_en;
      div_q   <= wr_div;
      high_q  <= wr_high;
      phase_q <= wr_phase;
    end
  end

  // Disabled channels park at their phase so a later enable starts aligned.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (restart || !en_q)
      cnt_q <= phase_e;
    else if (run)
      cnt_q <= (cnt_q >= div_e - 1'b1) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      outclk <= 1'b0;
    else
      outclk <= run && en_q && (cnt_q < high_e);
  end
endmodule

// File: rtl/clk_gen_multi.sv
// Multi-output programmable clock divider with settle/lock sequencing.
module clk_gen_multi
  import clk_gen_multi_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS = 4,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned LOCK_DELAY = 64,
  parameter int unsigned DIV_RESET  = 4,
  parameter int unsigned HIGH_RESET = 2
) (
  input logic           refclk,
  input logic           rst,
  clk_gen_multi_if.slave bus
);
  localparam int unsigned SEL_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
  localparam int unsigned SW    = $clog2(LOCK_DELAY);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_DELAY - 1);

  state_t                state_q, state_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  wr_valid, restart, run;
  logic                  locked_q, busy_q;
  logic [NUM_CLOCKS-1:0] outclk_w;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      locked_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      locked_q <= run;
      busy_q   <= !run;
    end
  end

  // A write cycle never counts as running, so locked and outputs drop on the write edge.
  always_comb begin
    wr_valid = bus.cfg_wr && (32'(bus.cfg_sel) < 32'(NUM_CLOCKS));
    state_d  = state_q;
    settle_d = settle_q;
    restart  = 1'b0;
    run      = 1'b0;
    case (state_q)
      SETTLE: begin
        if (wr_valid)
          settle_d = '0;
        else if (settle_q == SETTLE_LAST) begin
          state_d = LOCKED;
          restart = 1'b1;
        end else
          settle_d = settle_q + 1'b1;
      end
      LOCKED: begin
        if (wr_valid) begin
          state_d  = SETTLE;
          settle_d = '0;
        end else
          run = 1'b1;
      end
      default: state_d = SETTLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    clk_gen_channel #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET),
      .HIGH_RESET(HIGH_RESET)
    ) u_ch (
      .refclk  (refclk),
      .rst     (rst),
      .wr      (wr_valid && (bus.cfg_sel == SEL_W'(i))),
      .wr_en   (bus.cfg_en),
      .wr_div  (bus.cfg_div),
      .wr_high (bus.cfg_high),
      .wr_phase(bus.cfg_phase),
      .restart (restart),
      .run     (run),
      .outclk  (outclk_w[i])
    );
  end

  assign bus.outclk = outclk_w;
  assign bus.locked = locked_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi against a closed-form waveform model.
module tb_clk_gen_multi;
  localparam int unsigned NC = 3;
  localparam int unsigned CW = 16;
  localparam int unsigned LD = 64;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  always #5 refclk = ~refclk;

  clk_gen_multi_if #(.NUM_CLOCKS(NC), .CNT_W(CW)) bus ();

  clk_gen_multi #(
    .NUM_CLOCKS(NC), .CNT_W(CW), .LOCK_DELAY(LD), .DIV_RESET(4), .HIGH_RESET(2)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  int unsigned n = 0, r = 0;
  int unsigned compared = 0, mismatched = 0;
  int unsigned m_en[NC], m_div[NC], m_high[NC], m_phase[NC];

  function automatic int unsigned f_div(int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction
  function automatic int unsigned f_high(int unsigned h, int unsigned d);
    return (h < 1) ? 1 : ((h > d - 1) ? d - 1 : h);
  endfunction
  function automatic int unsigned f_phase(int unsigned p, int unsigned d);
    return (p < d) ? p : 0;
  endfunction

  function automatic logic exp_locked();
    return !rst && (n - r >= LD + 1);
  endfunction

  // Waveform k cycles after lock: position (phase + k) mod period, high while below high time.
  function automatic logic [NC-1:0] exp_out();
    logic [NC-1:0] v = '0;
    for (int i = 0; i < NC; i++) begin
      int unsigned d, h, p, k;
      d = f_div(m_div[i]);
      h = f_high(m_high[i], d);
      p = f_phase(m_phase[i], d);
      if (exp_locked() && m_en[i] != 0) begin
        k = n - r - (LD + 1);
        v[i] = ((p + k) % d) < h;
      end
    end
    return v;
  endfunction

  task automatic model_defaults();
    for (int i = 0; i < NC; i++) begin
      m_en[i] = 1; m_div[i] = 4; m_high[i] = 2; m_phase[i] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    n++;
    if (!rst && bus.cfg_wr && 32'(bus.cfg_sel) < NC) begin
      m_en[bus.cfg_sel]    = 32'(bus.cfg_en);
      m_div[bus.cfg_sel]   = 32'(bus.cfg_div);
      m_high[bus.cfg_sel]  = 32'(bus.cfg_high);
      m_phase[bus.cfg_sel] = 32'(bus.cfg_phase);
      r = n;
    end
    @(negedge refclk);
    bus.cfg_wr = 1'b0;
    check("locked", 32'(bus.locked), 32'(exp_locked()));
    check("busy",   32'(bus.busy),   32'(!exp_locked()));
    check("outclk", 32'(bus.outclk), 32'(exp_out()));
  endtask

  task automatic run(input int unsigned k);
    repeat (k) tick();
  endtask

  task automatic cfg_write(input int unsigned sel, input logic en, input int unsigned div,
                           input int unsigned high, input int unsigned phase);
    bus.cfg_wr    = 1'b1;
    bus.cfg_sel   = 2'(sel);
    bus.cfg_en    = en;
    bus.cfg_div   = CW'(div);
    bus.cfg_high  = CW'(high);
    bus.cfg_phase = CW'(phase);
    tick();
  endtask

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_sel = '0; bus.cfg_en = 1'b0;
    bus.cfg_div = '0; bus.cfg_high = '0; bus.cfg_phase = '0;
    model_defaults();
    run(3);
    rst = 1'b0;
    r = n;
    run(85);

    cfg_write(1, 1'b1, 5, 3, 2);
    run(85);

    cfg_write(0, 1'b1, 1, 0, 0);
    run(75);
    cfg_write(2, 1'b1, 6, 9, 7);
    run(85);

    cfg_write(2, 1'b0, 6, 9, 7);
    run(80);

    cfg_write(3, 1'b0, 1, 1, 1);
    run(12);

    for (int k = 0; k < 6; k++) begin
      cfg_write($urandom_range(0, 3), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 9), $urandom_range(0, 11), $urandom_range(0, 11));
      run($urandom_range(20, 95));
    end
    run(70);

    // Reset while some output is high; the search is bounded.
    for (int k = 0; k < 20 && bus.outclk == '0; k++) tick();
    check("outclk_high_before_rst", 32'(bus.outclk != '0), 32'd1);
    rst = 1'b1;
    #1;
    check("async_outclk", 32'(bus.outclk), 32'd0);
    check("async_locked", 32'(bus.locked), 32'd0);
    check("async_busy",   32'(bus.busy),   32'd1);
    model_defaults();
    run(4);
    rst = 1'b0;
    r = n;
    run(85);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
